// File: rtl/min_receive_fsm.sv
// MIN frame receiver: AA AA AA sync, ID, LEN, payload, CRC-32 (MSB first), EOF 55.
// Latency: o_valid / o_crc_err / o_frame_err pulse exactly 1 cycle after the deciding byte's i_valid.
// Backpressure: none; one byte is accepted on every cycle where i_en && i_valid, and i_en low freezes all state.
//
// Ports:
//   i_clk, i_rst_n          clock (rising edge) and synchronous active-low reset
//   i_en                    enable; when low, i_valid is ignored and the frame state holds
//   i_valid, i_data         one-cycle strobe plus the received UART byte
//   o_valid                 one-cycle pulse: good frame, o_id/o_len/o_data updated in the same cycle
//   o_id, o_len, o_data     last good frame; payload byte k sits at o_data[8*(MAX_PAYLOAD-k)-1 -: 8]
//   o_crc_err, o_frame_err  one-cycle error pulses (CRC mismatch / length overflow or missing EOF)
//   o_busy                  high whenever a frame is in progress
module min_receive_fsm #(
  parameter int MAX_PAYLOAD = 8
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_en,
  input  logic                     i_valid,
  input  logic [7:0]               i_data,
  output logic                     o_valid,
  output logic [7:0]               o_id,
  output logic [7:0]               o_len,
  output logic [8*MAX_PAYLOAD-1:0] o_data,
  output logic                     o_crc_err,
  output logic                     o_frame_err,
  output logic                     o_busy
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_ID      = 3'd1;
  localparam logic [2:0] S_LEN     = 3'd2;
  localparam logic [2:0] S_PAYLOAD = 3'd3;
  localparam logic [2:0] S_CRC     = 3'd4;
  localparam logic [2:0] S_EOF     = 3'd5;

  localparam logic [7:0]  SYNC_BYTE = 8'hAA;
  localparam logic [7:0]  EOF_BYTE  = 8'h55;
  localparam logic [7:0]  MAX_LEN   = 8'(MAX_PAYLOAD);
  localparam logic [31:0] CRC_INIT  = 32'hFFFF_FFFF;

  logic [2:0]               state;
  logic [1:0]               aa_cnt;
  logic [31:0]              crc;
  logic [31:0]              rx_crc;
  logic [7:0]               cnt;
  logic [7:0]               id_q;
  logic [7:0]               len_q;
  logic [8*MAX_PAYLOAD-1:0] shadow;
  logic                     crc_ok;

  // Reflected CRC-32, one byte, LSB first.
  function automatic logic [31:0] crc32_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'h0, d};
    for (int i = 0; i < 8; i++) begin
      r = r[0] ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
    end
    return r;
  endfunction

  logic        take;
  logic        is_sync;
  logic        resync;
  logic        unstuff;
  logic [31:0] crc_next;
  logic [31:0] rx_crc_next;

  assign take        = i_en & i_valid;
  assign is_sync     = (i_data == SYNC_BYTE);
  // A third AA in a row always wins: it restarts a frame from any state.
  assign resync      = take && is_sync && (aa_cnt == 2'd2);
  // Inside a frame, a 55 right after AA AA is a stuffing byte, not data.
  assign unstuff     = take && (i_data == EOF_BYTE) && (aa_cnt == 2'd2) && (state != S_IDLE);
  assign crc_next    = crc32_byte(crc, i_data);
  assign rx_crc_next = {rx_crc[23:0], i_data};

  assign o_busy = (state != S_IDLE);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state       <= S_IDLE;
      aa_cnt      <= 2'd0;
      crc         <= CRC_INIT;
      rx_crc      <= 32'd0;
      cnt         <= 8'd0;
      id_q        <= 8'd0;
      len_q       <= 8'd0;
      shadow      <= '0;
      crc_ok      <= 1'b0;
      o_valid     <= 1'b0;
      o_crc_err   <= 1'b0;
      o_frame_err <= 1'b0;
      o_id        <= 8'd0;
      o_len       <= 8'd0;
      o_data      <= '0;
    end else begin
      o_valid     <= 1'b0;
      o_crc_err   <= 1'b0;
      o_frame_err <= 1'b0;
      if (resync) begin
        state  <= S_ID;
        aa_cnt <= 2'd0;
        crc    <= CRC_INIT;
        rx_crc <= 32'd0;
        cnt    <= 8'd0;
        shadow <= '0;  // unfilled payload positions must read 0
        crc_ok <= 1'b0;
      end else if (unstuff) begin
        aa_cnt <= 2'd0;
      end else if (take) begin
        // aa_cnt cannot pass 2: an AA seen at 2 is the resync branch above.
        aa_cnt <= is_sync ? aa_cnt + 2'd1 : 2'd0;
        case (state)
          S_ID: begin
            id_q  <= i_data;
            crc   <= crc_next;
            state <= S_LEN;
          end
          S_LEN: begin
            len_q <= i_data;
            crc   <= crc_next;
            cnt   <= 8'd0;
            if (i_data > MAX_LEN) begin
              state       <= S_IDLE;
              o_frame_err <= 1'b1;
            end else if (i_data == 8'd0) begin
              state <= S_CRC;
            end else begin
              state <= S_PAYLOAD;
            end
          end
          S_PAYLOAD: begin
            crc <= crc_next;
            for (int k = 0; k < MAX_PAYLOAD; k++) begin
              if (cnt == 8'(k)) shadow[8*(MAX_PAYLOAD-k)-1 -: 8] <= i_data;
            end
            if (cnt == len_q - 8'd1) begin
              state <= S_CRC;
              cnt   <= 8'd0;
            end else begin
              cnt <= cnt + 8'd1;
            end
          end
          S_CRC: begin
            rx_crc <= rx_crc_next;
            if (cnt == 8'd3) begin
              state  <= S_EOF;
              cnt    <= 8'd0;
              crc_ok <= (rx_crc_next == ~crc);
            end else begin
              cnt <= cnt + 8'd1;
            end
          end
          S_EOF: begin
            state <= S_IDLE;
            if (i_data == EOF_BYTE) begin
              if (crc_ok) begin
                o_valid <= 1'b1;
                o_id    <= id_q;
                o_len   <= len_q;
                o_data  <= shadow;
              end else begin
                o_crc_err <= 1'b1;
              end
            end else if (!is_sync) begin
              // An AA here just drops the frame quietly; it may be the next header.
              o_frame_err <= 1'b1;
            end
          end
          default: state <= S_IDLE;  // S_IDLE waits for the header
        endcase
      end
    end
  end

endmodule

// File: tb/tb_min_receive_fsm.sv
// Self-checking bench for min_receive_fsm: frame-level reference model with randomized frames.
// Latency: each frame's outcome is checked 1 cycle after its deciding byte.
// Backpressure: none; the bench drives bytes with random idle gaps and enable gating.
module tb_min_receive_fsm;

  localparam int MAXP = 8;
  localparam int W    = 8 * MAXP;
  typedef logic [W-1:0] val_t;

  logic         i_clk = 1'b0;
  logic         i_rst_n = 1'b0;
  logic         i_en = 1'b1;
  logic         i_valid = 1'b0;
  logic [7:0]   i_data = 8'd0;
  logic         o_valid;
  logic [7:0]   o_id;
  logic [7:0]   o_len;
  logic [W-1:0] o_data;
  logic         o_crc_err;
  logic         o_frame_err;
  logic         o_busy;

  min_receive_fsm #(.MAX_PAYLOAD(MAXP)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_en(i_en), .i_valid(i_valid), .i_data(i_data),
    .o_valid(o_valid), .o_id(o_id), .o_len(o_len), .o_data(o_data),
    .o_crc_err(o_crc_err), .o_frame_err(o_frame_err), .o_busy(o_busy)
  );

  always #5 i_clk = ~i_clk;

  int n_checks = 0;
  int n_errors = 0;
  int n_v = 0, n_c = 0, n_f = 0;  // pulse counters seen by the monitor

  // Reference state: the last good frame's outputs.
  logic [7:0] exp_id = 8'd0;
  logic [7:0] exp_len = 8'd0;
  val_t       exp_data = '0;

  logic [31:0] crc_tab [0:255];
  logic [7:0]  pl [0:255];
  logic [7:0]  txq [$];
  int          enc_run;

  always @(negedge i_clk) begin
    if (i_rst_n) begin
      n_v += int'(o_valid);
      n_c += int'(o_crc_err);
      n_f += int'(o_frame_err);
    end
  end

  task automatic chk(input string tag, input val_t got, input val_t exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] b);
    return crc_tab[c[7:0] ^ b] ^ (c >> 8);
  endfunction

  // Sender-side stuffing: after any two AA in a row inside the frame, insert a 55.
  task automatic push_stuffed(input logic [7:0] b);
    txq.push_back(b);
    if (b == 8'hAA) begin
      enc_run++;
      if (enc_run == 2) begin
        txq.push_back(8'h55);
        enc_run = 0;
      end
    end else begin
      enc_run = 0;
    end
  endtask

  task automatic build_frame(input logic [7:0] id, input logic [7:0] len_field, input int npl,
                             input logic [31:0] crc_xor, input logic [7:0] eof, input bit stop_at_len);
    logic [31:0] c;
    logic [31:0] fcs;
    txq.delete();
    enc_run = 0;
    txq.push_back(8'hAA); txq.push_back(8'hAA); txq.push_back(8'hAA);
    c = 32'hFFFF_FFFF;
    c = crc_upd(c, id);        push_stuffed(id);
    c = crc_upd(c, len_field); push_stuffed(len_field);
    if (!stop_at_len) begin
      for (int i = 0; i < npl; i++) begin
        c = crc_upd(c, pl[i]);
        push_stuffed(pl[i]);
      end
      fcs = ~c ^ crc_xor;
      push_stuffed(fcs[31:24]); push_stuffed(fcs[23:16]);
      push_stuffed(fcs[15:8]);  push_stuffed(fcs[7:0]);
      txq.push_back(eof);
    end
  endtask

  task automatic idle_cycle();
    @(posedge i_clk); #1;
  endtask

  task automatic put_byte(input logic [7:0] b);
    i_data = b; i_valid = 1'b1;
    @(posedge i_clk); #1;
    i_valid = 1'b0;
  endtask

  task automatic gate_off_junk();
    i_en = 1'b0;
    for (int j = 0; j < 3; j++) put_byte(8'($urandom));
    i_en = 1'b1;
  endtask

  task automatic send_txq(input bit gate);
    int mid;
    mid = txq.size() / 2;
    foreach (txq[i]) begin
      repeat ($urandom_range(0, 2)) idle_cycle();
      if (gate && i == mid) gate_off_junk();
      put_byte(txq[i]);
    end
  endtask

  // ev: 0 good frame, 1 CRC error, 2 frame error
  task automatic do_frame(input string tag, input logic [7:0] id, input logic [7:0] len_field,
                          input int npl, input logic [31:0] crc_xor, input logic [7:0] eof, input bit gate);
    int  v0, c0, f0, ev;
    bit  ovf;
    logic pulse;
    ovf = (len_field > 8'(MAXP));
    build_frame(id, len_field, npl, crc_xor, eof, ovf);
    v0 = n_v; c0 = n_c; f0 = n_f;
    send_txq(gate);
    if (ovf || eof != 8'h55) ev = 2;
    else if (crc_xor != 32'd0) ev = 1;
    else ev = 0;
    case (ev)
      0:       pulse = o_valid;
      1:       pulse = o_crc_err;
      default: pulse = o_frame_err;
    endcase
    chk({tag, "_pulse"}, val_t'(pulse), val_t'(1));
    chk({tag, "_busy"}, val_t'(o_busy), val_t'(0));
    if (ev == 0) begin
      exp_id = id; exp_len = len_field; exp_data = '0;
      for (int i = 0; i < npl; i++) exp_data[8*(MAXP-i)-1 -: 8] = pl[i];
    end
    idle_cycle(); idle_cycle();
    chk({tag, "_nvalid"}, val_t'(n_v - v0), val_t'(ev == 0));
    chk({tag, "_ncrc"},   val_t'(n_c - c0), val_t'(ev == 1));
    chk({tag, "_nframe"}, val_t'(n_f - f0), val_t'(ev == 2));
    chk({tag, "_id"},   val_t'(o_id),  val_t'(exp_id));
    chk({tag, "_len"},  val_t'(o_len), val_t'(exp_len));
    chk({tag, "_data"}, o_data, exp_data);
  endtask

  task automatic load_good_payload();
    logic [63:0] g;
    g = 64'h1122_3344_5566_7788;
    for (int i = 0; i < 8; i++) pl[i] = g[63-8*i -: 8];
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_valid"}, val_t'(o_valid), val_t'(0));
    chk({tag, "_crc"},   val_t'(o_crc_err), val_t'(0));
    chk({tag, "_ferr"},  val_t'(o_frame_err), val_t'(0));
    chk({tag, "_busy"},  val_t'(o_busy), val_t'(0));
    chk({tag, "_id"},    val_t'(o_id), val_t'(0));
    chk({tag, "_len"},   val_t'(o_len), val_t'(0));
    chk({tag, "_data"},  o_data, val_t'(0));
  endtask

  initial begin
    int kind, len;
    logic [31:0] c;

    for (int i = 0; i < 256; i++) begin
      c = 32'(i);
      for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
      crc_tab[i] = c;
    end

    // Reset state
    i_rst_n = 1'b0;
    idle_cycle(); idle_cycle();
    check_all_zero("reset");
    i_rst_n = 1'b1;
    idle_cycle();

    // Known good frame
    load_good_payload();
    do_frame("good", 8'h01, 8'h08, 8, 32'd0, 8'h55, 1'b0);
    chk("good_value", o_data, val_t'(64'h1122_3344_5566_7788));

    // Stuffing: payload AA AA 10 goes out as AA AA 55 10
    pl[0] = 8'hAA; pl[1] = 8'hAA; pl[2] = 8'h10;
    do_frame("stuff", 8'h02, 8'h03, 3, 32'd0, 8'h55, 1'b0);
    chk("stuff_value", o_data, val_t'(64'hAAAA_1000_0000_0000));

    // CRC corruption: outputs must keep the stuffed frame's values
    load_good_payload();
    do_frame("crcbad", 8'h01, 8'h08, 8, 32'h0000_0001, 8'h55, 1'b0);

    // Length overflow and missing EOF
    do_frame("ovf", 8'h01, 8'h09, 0, 32'd0, 8'h55, 1'b0);
    do_frame("noeof", 8'h01, 8'h08, 8, 32'd0, 8'h00, 1'b0);

    // Resync: truncated frame then a fresh header and a good frame
    put_byte(8'hAA); put_byte(8'hAA); put_byte(8'hAA);
    put_byte(8'h01); put_byte(8'h04); put_byte(8'h12);
    chk("resync_busy", val_t'(o_busy), val_t'(1));
    do_frame("resync", 8'h01, 8'h08, 8, 32'd0, 8'h55, 1'b0);

    // Reset in the middle of the payload
    put_byte(8'hAA); put_byte(8'hAA); put_byte(8'hAA);
    put_byte(8'h03); put_byte(8'h05); put_byte(8'h01); put_byte(8'h02);
    chk("midrst_busy", val_t'(o_busy), val_t'(1));
    i_rst_n = 1'b0;
    idle_cycle();
    check_all_zero("midrst");
    i_rst_n = 1'b1;
    exp_id = 8'd0; exp_len = 8'd0; exp_data = '0;
    do_frame("afterrst", 8'h01, 8'h08, 8, 32'd0, 8'h55, 1'b0);

    // Enable gating mid-frame
    for (int i = 0; i < 5; i++) pl[i] = 8'(8'h30 + i);
    do_frame("gate", 8'h07, 8'h05, 5, 32'd0, 8'h55, 1'b1);

    // Randomized frames
    for (int n = 0; n < 40; n++) begin
      kind = $urandom_range(0, 9);
      len  = $urandom_range(0, MAXP);
      for (int i = 0; i < len; i++) pl[i] = ($urandom_range(0, 3) == 0) ? 8'hAA : 8'($urandom);
      case (kind)
        6: do_frame("rnd_crc", 8'($urandom), 8'(len), len, 32'h1 << $urandom_range(0, 31), 8'h55, 1'b0);
        7: do_frame("rnd_eof", 8'($urandom), 8'(len), len, 32'd0, 8'($urandom_range(0, 8'h54)), 1'b0);
        8: do_frame("rnd_ovf", 8'($urandom), 8'($urandom_range(MAXP + 1, 8'hA9)), 0, 32'd0, 8'h55, 1'b0);
        9: do_frame("rnd_gate", 8'($urandom), 8'(len), len, 32'd0, 8'h55, 1'b1);
        default: do_frame("rnd_good", 8'($urandom), 8'(len), len, 32'd0, 8'h55, 1'b0);
      endcase
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/min_receive_fsm.md
MIN_RECEIVE_FSM -- requirements
Module: min_receive_fsm

Interface
REQ-001 SHALL have parameter MAX_PAYLOAD, default 8, giving the maximum accepted payload bytes (1..255).
REQ-002 SHALL have port i_clk, input, 1, the single clock; all logic is on its rising edge.
REQ-003 SHALL have port i_rst_n, input, 1; reset is synchronous and active-low.
REQ-004 SHALL have port i_en, input, 1, the enable; when low, i_valid is ignored and all state holds.
REQ-005 SHALL have port i_valid, input, 1, a one-cycle strobe marking a received UART byte on i_data.
REQ-006 SHALL have port i_data, input, 8, the received byte.
REQ-007 SHALL have port o_valid, output, 1, a one-cycle pulse marking a good frame.
REQ-008 SHALL have port o_id, output, 8, the frame ID/control byte.
REQ-009 SHALL have port o_len, output, 8, the payload length.
REQ-010 SHALL have port o_data, output, 8*MAX_PAYLOAD, the payload.
REQ-011 SHALL have port o_crc_err, output, 1, a one-cycle pulse on CRC mismatch.
REQ-012 SHALL have port o_frame_err, output, 1, a one-cycle pulse on length overflow or a missing EOF.
REQ-013 SHALL have port o_busy, output, 1, high whenever the state is not IDLE.

Function
REQ-014 SHALL implement the MIN frame format: header AA AA AA, ID, LEN, LEN payload bytes, CRC32 (4 bytes, MSB first), EOF 55.
REQ-015 SHALL use these states: IDLE, ID, LEN, PAYLOAD, CRC, EOF.
REQ-016 SHALL count consecutive 0xAA bytes in every state; the third consecutive 0xAA forces state ID, clears CRC/counters, and emits no error pulse (resync).
REQ-017 SHALL treat byte stuffing as follows: in states ID..EOF, a 0x55 received immediately after two consecutive 0xAA is discarded, clears the AA count, and advances nothing.
REQ-018 SHALL follow these transitions: ID->LEN on any byte; LEN->PAYLOAD if 1<=LEN<=MAX_PAYLOAD; LEN->CRC if LEN=0; LEN->IDLE with o_frame_err if LEN>MAX_PAYLOAD; PAYLOAD->CRC after LEN bytes; CRC->EOF after 4 bytes; EOF->IDLE always.
REQ-019 SHALL compute the CRC as CRC-32, reflected polynomial 0xEDB88320, init 0xFFFFFFFF, final XOR 0xFFFFFFFF, processed LSB-first over unstuffed ID, LEN and payload bytes only, one byte per accepted i_valid.
REQ-020 SHALL shift the received CRC bytes into a 32-bit register MSB first and compare it with the final computed CRC on entry to EOF.
REQ-021 SHALL, in EOF with byte 0x55 and a CRC match, pulse o_valid and update o_id, o_len and o_data in the same registered cycle.
REQ-022 SHALL, in EOF with byte 0x55 and a CRC mismatch, pulse o_crc_err and leave the outputs unchanged.
REQ-023 SHALL, in EOF with any byte other than 0x55 or 0xAA, pulse o_frame_err and return to IDLE.
REQ-024 SHALL give latency as follows: o_valid, o_crc_err and o_frame_err assert exactly 1 cycle after the i_valid of the deciding byte.
REQ-025 SHALL place payload byte k (k=0 first received) at o_data[8*(MAX_PAYLOAD-k)-1 -: 8]; bytes at k>=LEN read 0.
REQ-026 SHALL hold o_id, o_len and o_data stable between o_valid pulses, and never change them on an error.
REQ-027 SHALL collect the payload in a shadow register and copy it to o_data only on o_valid, so a partial frame never disturbs the output.
REQ-028 SHALL accept back-to-back i_valid on consecutive cycles without loss.
REQ-029 SHALL drop a frame silently if a new header arrives mid-frame, and start the new frame.
REQ-030 SHALL, with i_en low during a frame, resume that frame when i_en returns high.

Reset
REQ-031 SHALL, while i_rst_n is low at a clock edge, set state IDLE, clear the AA count, CRC and counters, and drive o_valid, o_crc_err, o_frame_err, o_busy = 0 and o_id, o_len, o_data = 0.
REQ-032 SHALL, on reset mid-frame, discard the frame; the next frame decodes normally.

Verification
REQ-033 SHALL verify a good frame: AA AA AA 01 08 11 22 33 44 55 66 77 88 + model CRC + 55 -> one o_valid, o_id=01, o_len=08, o_data=0x1122334455667788.
REQ-034 SHALL verify stuffing: payload AA AA 10 sent as AA AA 55 10 (LEN=3) -> o_data upper 3 bytes AA AA 10, lower 5 bytes 0, CRC matches.
REQ-035 SHALL verify CRC corruption: the good frame with the last CRC byte XOR 0x01 -> o_crc_err pulse, no o_valid, outputs keep their previous values.
REQ-036 SHALL verify overflow and a missing EOF: LEN=09 -> o_frame_err 1 cycle after the LEN byte, o_busy=0; a good frame with EOF byte 0x00 -> o_frame_err.
REQ-037 SHALL verify resync and reset: AA AA AA 01 04 12 then AA AA AA + good frame -> exactly one o_valid, for the second frame; i_rst_n low during PAYLOAD -> all outputs 0, next frame accepted.
REQ-038 SHALL verify enable gating: i_en low while 3 bytes are strobed mid-frame -> bytes ignored; the frame completes correctly after i_en returns high.
